fnd_time_display: RTL and testbench

FND_TIME_DISPLAY -- requirements
Module: fnd_time_display

---
 rtl/fnd_pkg.sv | 40 ++++
 rtl/bin2bcd_seq.sv | 95 +++++++++
 rtl/fnd_time_display.sv | 150 +++++++++++++++
 tb/tb_fnd_time_display.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared segment codes and helpers for the FND time display
//
// Purpose: common constants for the four-digit seven-segment time display.
//   SEG_TABLE   : active-low segment codes for digits 0..9, dp off (bit7 = dp, bits6:0 = g..a)
//   FND_BLANK   : all segments off
//   FND_DP_MASK : AND mask that lights the decimal point
//   seg_code()  : digit -> segment code, blank for non-decimal nibbles
//   clamp99()   : saturate a 7-bit value at 99
//   conv_state_t: states of the sequential binary-to-BCD converter
package fnd_pkg;

  localparam logic [7:0] SEG_TABLE [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  localparam logic [7:0] FND_BLANK   = 8'hFF;
  localparam logic [7:0] FND_DP_MASK = 8'h7F;

  // One shift per input bit.
  localparam int BCD_STEPS = 7;

  typedef enum logic [1:0] {
    CV_IDLE  = 2'd0,
    CV_SHIFT = 2'd1,
    CV_LATCH = 2'd2
  } conv_state_t;

  function automatic logic [7:0] seg_code(input logic [3:0] digit);
    if (digit > 4'd9) begin
      return FND_BLANK;
    end
    return SEG_TABLE[digit];
  endfunction

  function automatic logic [6:0] clamp99(input logic [6:0] value);
    return (value > 7'd99) ? 7'd99 : value;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to two-digit BCD converter
//
// Purpose: converts a 7-bit binary value (0..99) into tens/ones BCD digits.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_start        : one-cycle pulse, loads i_bin and (re)starts a conversion
//   i_bin          : binary value to convert
//   o_busy         : conversion in progress
//   o_done         : one-cycle pulse when o_tens/o_ones have been updated
//   o_tens, o_ones : converted digits, updated together 8 cycles after i_start
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [6:0] i_bin,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  localparam logic [2:0] STEP_LAST = 3'(BCD_STEPS - 1);

  conv_state_t state_q;
  conv_state_t state_n;
  logic [2:0]  step_q;
  // {tens, ones, remaining binary bits}
  logic [14:0] sr_q;
  logic [14:0] sr_adj;
  logic [14:0] sr_shift;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= CV_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // A start pulse always wins so a fresh capture restarts the conversion.
  always_comb begin
    state_n = state_q;
    if (i_start) begin
      state_n = CV_SHIFT;
    end else begin
      case (state_q)
        CV_IDLE:  state_n = CV_IDLE;
        CV_SHIFT: if (step_q == STEP_LAST) state_n = CV_LATCH;
        CV_LATCH: state_n = CV_IDLE;
        default:  state_n = CV_IDLE;
      endcase
    end
  end

  // Add 3 to any BCD nibble >= 5 before the shift so it carries correctly.
  always_comb begin
    sr_adj = sr_q;
    if (sr_adj[10:7] >= 4'd5) sr_adj[10:7] = sr_adj[10:7] + 4'd3;
    if (sr_adj[14:11] >= 4'd5) sr_adj[14:11] = sr_adj[14:11] + 4'd3;
    sr_shift = {sr_adj[13:0], 1'b0};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sr_q   <= '0;
      step_q <= '0;
      o_tens <= '0;
      o_ones <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        sr_q   <= {8'd0, i_bin};
        step_q <= '0;
      end else begin
        case (state_q)
          CV_SHIFT: begin
            sr_q   <= sr_shift;
            step_q <= step_q + 3'd1;
          end
          CV_LATCH: begin
            o_tens <= sr_q[14:11];
            o_ones <= sr_q[10:7];
            o_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_busy = (state_q != CV_IDLE);

endmodule

// File: rtl/fnd_time_display.sv
// rtl/fnd_time_display.sv - multiplexed four-digit SS.HH countdown display driver
//
// Purpose: scans four common-anode digits, showing a per-frame snapshot of
// seconds and hundredths; blinks the display while the snapshot is 00.00.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_sec, i_msec  : remaining seconds / hundredths (values above 99 show as 99)
//   o_fnd_com      : active-low digit enables, bit0 = rightmost digit
//   o_fnd_font     : active-low segments, bit7 = dp, bits6:0 = g..a
//   o_zero         : high while the displayed snapshot is 00.00
module fnd_time_display
  import fnd_pkg::*;
#(
  parameter int P_SCAN_DIV     = 100000,
  parameter int P_BLINK_FRAMES = 125
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [6:0] i_sec,
  input  logic [6:0] i_msec,
  output logic [3:0] o_fnd_com,
  output logic [7:0] o_fnd_font,
  output logic       o_zero
);

  localparam int SCAN_W  = (P_SCAN_DIV > 1) ? $clog2(P_SCAN_DIV) : 1;
  localparam int BLINK_W = (P_BLINK_FRAMES > 1) ? $clog2(P_BLINK_FRAMES) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(P_SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(P_BLINK_FRAMES - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         digit_idx;
  logic               scan_tc;
  logic               frame_tick;
  logic [6:0]         sec_snap;
  logic [6:0]         msec_snap;
  logic               conv_start;
  logic               sec_busy, msec_busy;
  logic               sec_done, msec_done;
  logic [3:0]         sec_tens, sec_ones;
  logic [3:0]         msec_tens, msec_ones;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_off;
  logic [3:0]         com_n;
  logic [7:0]         font_n;

  assign scan_tc    = (scan_cnt == SCAN_LAST);
  assign frame_tick = scan_tc && (digit_idx == 2'd3);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_tc) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  // Inputs are only looked at on the frame boundary; the converters start
  // from the snapshot one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sec_snap   <= '0;
      msec_snap  <= '0;
      conv_start <= 1'b0;
    end else begin
      conv_start <= frame_tick;
      if (frame_tick) begin
        sec_snap  <= clamp99(i_sec);
        msec_snap <= clamp99(i_msec);
      end
    end
  end

  bin2bcd_seq u_sec_bcd (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (conv_start),
    .i_bin   (sec_snap),
    .o_busy  (sec_busy),
    .o_done  (sec_done),
    .o_tens  (sec_tens),
    .o_ones  (sec_ones)
  );

  bin2bcd_seq u_msec_bcd (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (conv_start),
    .i_bin   (msec_snap),
    .o_busy  (msec_busy),
    .o_done  (msec_done),
    .o_tens  (msec_tens),
    .o_ones  (msec_ones)
  );

  // Zero is judged on the converted digits, so it tracks what is displayed
  // rather than the raw inputs. A completion superseded by a restart is ignored.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_zero <= 1'b0;
    end else if (sec_done && msec_done && !sec_busy && !msec_busy) begin
      o_zero <= (sec_tens == 4'd0) && (sec_ones == 4'd0) &&
                (msec_tens == 4'd0) && (msec_ones == 4'd0);
    end
  end

  // Blink phase only runs while zero is shown; otherwise held in the on phase.
  always_ff @(posedge i_clk) begin
    if (i_reset || !o_zero) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    font_n = FND_BLANK;
    case (digit_idx)
      2'd0: font_n = seg_code(msec_ones);
      2'd1: font_n = seg_code(msec_tens);
      2'd2: font_n = seg_code(sec_ones) & FND_DP_MASK;
      2'd3: font_n = (sec_tens == 4'd0) ? FND_BLANK : seg_code(sec_tens);
      default: font_n = FND_BLANK;
    endcase
    com_n = ~(4'b0001 << digit_idx);
    if (o_zero && blink_off) begin
      com_n = 4'b1111;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_fnd_com  <= 4'b1111;
      o_fnd_font <= FND_BLANK;
    end else begin
      o_fnd_com  <= com_n;
      o_fnd_font <= font_n;
    end
  end

endmodule

// File: tb/tb_fnd_time_display.sv
// tb/tb_fnd_time_display.sv - self-checking bench for fnd_time_display
module tb_fnd_time_display;

  localparam int DIV   = 4;
  localparam int BLINK = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] sec = 7'd0;
  logic [6:0] msec = 7'd0;
  logic [3:0] com;
  logic [7:0] font;
  logic       zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fnd_time_display #(
    .P_SCAN_DIV     (DIV),
    .P_BLINK_FRAMES (BLINK)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_sec      (sec),
    .i_msec     (msec),
    .o_fnd_com  (com),
    .o_fnd_font (font),
    .o_zero     (zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time is counted in clock edges since reset release; the digit shown, the
  // snapshot cadence and the blink phase follow from plain arithmetic on it.
  logic [7:0] seg [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct {
    int at;
    int s;
    int m;
  } upd_t;

  upd_t       pend [$];
  upd_t       u;
  int         k;
  int         dsec, dmsec;
  int         zstart;
  int         oidx;
  int         nfr;
  bit         zero_m, done_m, dark, mvalid = 1'b0;
  logic [3:0] onehot;
  logic [3:0] e_com;
  logic [7:0] e_font;
  logic       e_zero;

  function automatic int clamp(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      k = 0; dsec = 0; dmsec = 0; zstart = 0;
      zero_m = 1'b0; done_m = 1'b0;
      pend.delete();
      e_com = 4'hF; e_font = 8'hFF; e_zero = 1'b0;
      mvalid = 1'b1;
    end else begin
      k++;
      oidx = ((k - 1) / DIV) % 4;
      case (oidx)
        0: e_font = seg[dmsec % 10];
        1: e_font = seg[dmsec / 10];
        2: e_font = seg[dsec % 10] & 8'h7F;
        default: e_font = (dsec / 10 == 0) ? 8'hFF : seg[dsec / 10];
      endcase
      dark = 1'b0;
      if (zero_m) begin
        nfr  = (k - 1) / FRAME - zstart / FRAME;
        dark = ((nfr / BLINK) % 2) == 1;
      end
      onehot = 4'b0001 << oidx;
      e_com  = dark ? 4'hF : ~onehot;
      if (done_m) begin
        if (!zero_m && dsec == 0 && dmsec == 0) zstart = k;
        zero_m = (dsec == 0 && dmsec == 0);
      end
      e_zero = zero_m;
      done_m = 1'b0;
      if (pend.size() > 0 && pend[0].at == k) begin
        dsec  = pend[0].s;
        dmsec = pend[0].m;
        done_m = 1'b1;
        void'(pend.pop_front());
      end
      // Snapshot on each frame boundary, visible 9 edges later.
      if (k % FRAME == 0) begin
        u.at = k + 9;
        u.s  = clamp(int'(sec));
        u.m  = clamp(int'(msec));
        pend.push_back(u);
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("cyc_com", 32'(com), 32'(e_com));
      chk("cyc_font", 32'(font), 32'(e_font));
      chk("cyc_zero", 32'(zero), 32'(e_zero));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_com(input logic [3:0] c, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (com === c) break;
    end
    chk(name, 32'(com), 32'(c));
  endtask

  task automatic show_frame(input logic [7:0] f3, input logic [7:0] f2,
                            input logic [7:0] f1, input logic [7:0] f0,
                            input string tag);
    logic [8:0] got [4];
    for (int i = 0; i < 4; i++) got[i] = 9'h1FF;
    repeat (2 * FRAME + 12) @(negedge clk);
    repeat (FRAME) begin
      @(negedge clk);
      case (com)
        4'b1110: got[0] = {1'b0, font};
        4'b1101: got[1] = {1'b0, font};
        4'b1011: got[2] = {1'b0, font};
        4'b0111: got[3] = {1'b0, font};
        default: ;
      endcase
    end
    chk({tag, "_d3"}, 32'(got[3]), 32'(f3));
    chk({tag, "_d2"}, 32'(got[2]), 32'(f2));
    chk({tag, "_d1"}, 32'(got[1]), 32'(f1));
    chk({tag, "_d0"}, 32'(got[0]), 32'(f0));
  endtask

  int ndark;
  int wi;

  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("rst_com", 32'(com), 32'h0F);
      chk("rst_font", 32'(font), 32'hFF);
      chk("rst_zero", 32'(zero), 32'h0);
    end
    sec = 7'd25; msec = 7'd37;
    reset = 1'b0;
    @(negedge clk);
    chk("rel_com", 32'(com), 32'hE);
    chk("rel_font", 32'(font), 32'hC0);

    show_frame(8'hA4, 8'h12, 8'hB0, 8'hF8, "t25_37");

    sec = 7'd7; msec = 7'd5;
    show_frame(8'hFF, 8'h78, 8'hC0, 8'h92, "t07_05");

    sec = 7'd120; msec = 7'd100;
    show_frame(8'h90, 8'h10, 8'h90, 8'h90, "tclamp");

    // Zero snapshot: blink two frames on, two frames off.
    sec = 7'd0; msec = 7'd0;
    for (wi = 0; wi < 60; wi++) begin
      @(negedge clk);
      if (zero === 1'b1) break;
    end
    chk("zero_rise", 32'(zero), 32'h1);
    wait_com(4'hF, 80, "blink_dark");
    ndark = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (com === 4'hF) ndark++;
      @(negedge clk);
    end
    chk("blink_dark_cnt", 32'(ndark), 32'(2 * FRAME));
    chk("zero_hold", 32'(zero), 32'h1);

    sec = 7'd3;
    for (wi = 0; wi < 50; wi++) begin
      @(negedge clk);
      if (zero === 1'b0) break;
    end
    chk("zero_fall", 32'(zero), 32'h0);
    @(negedge clk);
    ndark = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (com === 4'hF) ndark++;
    end
    chk("noblink_cnt", 32'(ndark), 32'h0);

    // Mid-frame input change must wait for the next snapshot.
    sec = 7'd12; msec = 7'd50;
    show_frame(8'hF9, 8'h24, 8'h92, 8'hC0, "t12_50");
    wait_com(4'b1101, 40, "find_idx1");
    sec = 7'd34;
    wait_com(4'b1011, 40, "find_idx2");
    chk("hold_d2", 32'(font), 32'h24);
    wait_com(4'b0111, 40, "find_idx3");
    chk("hold_d3", 32'(font), 32'hF9);
    show_frame(8'hB0, 8'h19, 8'h92, 8'hC0, "t34_50");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
